// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch front end.
package cpu_pkg;

  localparam int unsigned      INSTR_W          = 32;
  localparam logic [31:0]      DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR      = '0;

  typedef enum logic {
    FETCH,
    FLUSH
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// In-order storage for the prefetch queue; synchronous clear empties it in one cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word requests and queues
// {PC+4, instruction} pairs for IF/ID, flushing stale responses after a redirect.
module fetch_prefetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic               Clk,
  input  logic               Rst,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               stall,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  PCAddResult,
  output logic               inst_valid
);

  localparam int unsigned       CNT_W    = $clog2(DEPTH) + 1;
  localparam int unsigned       ENT_W    = ADDR_W + INSTR_W;
  localparam logic [ADDR_W-1:0] WORD_MSK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] START_PC = RESET_PC & WORD_MSK;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  w_out_nxt;
  logic [CNT_W-1:0]  r_drop;
  logic [CNT_W-1:0]  w_drop_nxt;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_inflight;
  logic              w_credit;
  logic              w_req_valid;
  logic              w_hs;
  logic              w_resp_ok;
  logic              w_push;
  logic              w_pop;
  logic              w_clear;
  logic              w_full;
  logic              w_empty;
  logic              w_head_valid;
  logic [ENT_W-1:0]  w_push_data;
  logic [ENT_W-1:0]  w_head;

  assign w_redirect_pc = redirect_pc & WORD_MSK;
  assign w_inflight    = {1'b0, w_count} + {1'b0, r_outstanding};
  assign w_credit      = (w_inflight < (CNT_W+1)'(DEPTH));
  assign w_req_valid   = !Rst && (r_state == FETCH) && w_credit && !redirect;
  assign w_hs          = w_req_valid && imem_req_ready;
  assign w_resp_ok     = imem_resp_valid && (r_outstanding != '0);
  // Responses return in request order, so the oldest outstanding PC is tracked separately.
  assign w_push_data   = {r_resp_pc + ADDR_W'(4), imem_resp_data};

  always_comb begin
    w_out_nxt = r_outstanding;
    case ({w_hs, w_resp_ok})
      2'b10:   w_out_nxt = r_outstanding + CNT_W'(1);
      2'b01:   w_out_nxt = r_outstanding - CNT_W'(1);
      default: w_out_nxt = r_outstanding;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_clear     = redirect;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      FETCH: begin
        if (redirect) begin
          w_drop_nxt = w_out_nxt;
          if (w_out_nxt != '0) w_state_nxt = FLUSH;
        end else begin
          w_push = w_resp_ok && !w_full;
          w_pop  = w_head_valid && !stall;
        end
      end
      FLUSH: begin
        if (w_resp_ok) w_drop_nxt = r_drop - CNT_W'(1);
        if (w_drop_nxt == '0) w_state_nxt = FETCH;
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= FETCH;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_fetch_pc    <= START_PC;
      r_resp_pc     <= START_PC;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_out_nxt;
      r_drop        <= w_drop_nxt;
      if (redirect) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
      end else begin
        if (w_hs)   r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        if (w_push) r_resp_pc  <= r_resp_pc + ADDR_W'(4);
      end
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (w_push),
    .pop   (w_pop),
    .clear (w_clear),
    .wdata (w_push_data),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_head_valid   = !Rst && !w_empty;
  assign inst_valid     = w_head_valid;
  assign Instruction    = w_head_valid ? w_head[INSTR_W-1:0] : NOP_INSTR;
  assign PCAddResult    = w_head_valid ? w_head[ENT_W-1:INSTR_W] : '0;
  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;

endmodule
